// File: rtl/xc_mmul_unit.sv
// Purpose: XCrypto wide-result unit for xc.mmul.3 / xc.madd.3 / xc.msub.3 -> {rsp_hi, rsp_lo}.
// Latency: MMUL valid STEPS edges after accept; MADD/MSUB/illegal valid one edge after accept.
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until rsp_ready.
module xc_mmul_unit #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_lo,
  output logic [XLEN-1:0] rsp_hi,
  output logic            rsp_err
);

  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW    = $clog2(2 * XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     count;
  logic              illegal;

  logic [2*XLEN-1:0] op_a;
  logic [2*XLEN-1:0] op_b;
  logic [2*XLEN-1:0] op_c;
  logic [2*XLEN-1:0] pp;
  logic [SW-1:0]     shamt;
  logic              accept;
  logic              last_step;

  assign req_ready = (state == IDLE) && !flush && !g_reset;
  assign accept    = req_valid && req_ready;
  assign last_step = (count == CW'(STEPS - 1));

  // Result data is exposed only while a response is presented; partial sums stay hidden.
  assign rsp_lo = (state == DONE) ? acc[XLEN-1:0]      : '0;
  assign rsp_hi = (state == DONE) ? acc[2*XLEN-1:XLEN] : '0;

  // Zero-extended operands and the current radix partial product.
  always_comb begin
    op_a  = {{XLEN{1'b0}}, req_rs1};
    op_b  = {{XLEN{1'b0}}, req_rs2};
    op_c  = {{XLEN{1'b0}}, req_rs3};
    shamt = SW'(count) * SW'(RADIX_BITS);
    pp    = ({{XLEN{1'b0}}, mcand} *
             {{(2*XLEN-RADIX_BITS){1'b0}}, mplier[RADIX_BITS-1:0]}) << shamt;
  end

  // Control FSM plus datapath registers. Single-cycle ops pass through one BUSY cycle
  // with a zero multiplier on the final step, so every op reaches DONE through the same
  // BUSY->DONE transition and all response flags are loaded in one place.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      illegal   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            mcand   <= req_rs1;
            illegal <= 1'b0;
            case (req_op)
              2'b00: begin
                acc    <= op_c;
                mplier <= req_rs2;
                count  <= '0;
              end
              2'b01: begin
                acc    <= op_a + op_b + op_c;
                mplier <= '0;
                count  <= CW'(STEPS - 1);
              end
              2'b10: begin
                acc    <= op_a - op_b - op_c;
                mplier <= '0;
                count  <= CW'(STEPS - 1);
              end
              default: begin
                acc     <= '0;
                mplier  <= '0;
                count   <= CW'(STEPS - 1);
                illegal <= 1'b1;
              end
            endcase
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc + pp;
            mplier <= mplier >> RADIX_BITS;
            count  <= count + CW'(1);
            if (last_step) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= illegal;
            end
          end
        end
        DONE: begin
          if (flush || rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
